// File: rtl/store_drain_buffer_pkg.sv
// Shared types and helpers for the committed-store drain buffer.
//   store_entry_t : one buffered store {address, data, microop}
//   MO_SB/SH/SW   : store microop encodings
//   byte_mask()   : 4-bit byte-lane mask for an access size and low address bits
//   store_size()  : access size (0 byte, 1 half, 2 word) of a store microop
package store_drain_buffer_pkg;

    localparam int SDB_ADDR_BITS  = 32;
    localparam int SDB_DATA_WIDTH = 32;
    localparam int SDB_MICROOP    = 5;

    localparam logic [SDB_MICROOP-1:0] MO_SB = 5'b00110;
    localparam logic [SDB_MICROOP-1:0] MO_SH = 5'b00111;
    localparam logic [SDB_MICROOP-1:0] MO_SW = 5'b01000;

    typedef struct packed {
        logic [SDB_ADDR_BITS-1:0]  address;
        logic [SDB_DATA_WIDTH-1:0] data;
        logic [SDB_MICROOP-1:0]    microop;
    } store_entry_t;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'(4'b0001 << a);
            2'd1:    m = 4'(4'b0011 << a);
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Anything that is not SB/SH is treated as a full word.
    function automatic logic [1:0] store_size(input logic [SDB_MICROOP-1:0] microop);
        logic [1:0] s;
        case (microop)
            MO_SB:   s = 2'd0;
            MO_SH:   s = 2'd1;
            default: s = 2'd2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/store_drain_buffer_fwd_search.sv
// Youngest-first store-to-load overlap search.
//   entries/valid : buffer storage and per-slot valid bits
//   head/tail     : oldest slot and next write slot (tail-1 is youngest)
//   lookup_*      : load address and size (0 byte, 1 half, 2 word)
//   hit/data      : youngest overlapping store matches the load exactly
//   stall         : youngest overlapping store cannot be forwarded
module store_drain_buffer_fwd_search
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  store_entry_t              entries [DEPTH],
    input  logic [DEPTH-1:0]          valid,
    input  logic [PTR_W-1:0]          head,
    input  logic [PTR_W-1:0]          tail,
    input  logic [SDB_ADDR_BITS-1:0]  lookup_address,
    input  logic [1:0]                lookup_size,
    output logic                      hit,
    output logic                      stall,
    output logic [SDB_DATA_WIDTH-1:0] data
);

    always_comb begin
        logic [3:0]       load_mask;
        logic [3:0]       st_mask;
        logic [PTR_W-1:0] idx;
        logic             found;
        logic             done;
        hit       = 1'b0;
        stall     = 1'b0;
        data      = '0;
        found     = 1'b0;
        done      = 1'b0;
        idx       = '0;
        st_mask   = '0;
        load_mask = byte_mask(lookup_size, lookup_address[1:0]);
        // Walk from the youngest slot back towards head; pointer arithmetic
        // wraps modulo DEPTH, so age order survives pointer wrap-around.
        // The cast makes i+1 == DEPTH wrap to 0, i.e. idx == tail (full case).
        for (int i = 0; i < DEPTH; i++) begin
            idx     = tail - PTR_W'(i + 1);
            st_mask = byte_mask(store_size(entries[idx].microop), entries[idx].address[1:0]);
            if (!found && !done && valid[idx] &&
                entries[idx].address[SDB_ADDR_BITS-1:2] == lookup_address[SDB_ADDR_BITS-1:2] &&
                (st_mask & load_mask) != 4'b0000) begin
                found = 1'b1;
                if (entries[idx].address == lookup_address &&
                    store_size(entries[idx].microop) == lookup_size) begin
                    hit  = 1'b1;
                    data = entries[idx].data;
                end else begin
                    stall = 1'b1;
                end
            end
            if (idx == head) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_drain_buffer.sv
// FIFO of committed stores: filled by ROB retirement, drained in order to the
// data-cache write port, with a youngest-first forwarding lookup for loads.
//   commit_*  : store retirement (valid/ready handshake)
//   wb_*      : head store presented to the cache (wb_valid also feeds the
//               LSU port-hazard signal)
//   lookup_*  : load forwarding query, hit/data or stall
//   empty/full: occupancy flags
module store_drain_buffer
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_BITS  = SDB_ADDR_BITS,
    parameter int DATA_WIDTH = SDB_DATA_WIDTH,
    parameter int MICROOP    = SDB_MICROOP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic [ADDR_BITS-1:0]  commit_address,
    input  logic [DATA_WIDTH-1:0] commit_data,
    input  logic [MICROOP-1:0]    commit_microop,
    output logic                  commit_ready,
    output logic                  wb_valid,
    output logic [ADDR_BITS-1:0]  wb_address,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [MICROOP-1:0]    wb_microop,
    input  logic                  wb_ready,
    input  logic [ADDR_BITS-1:0]  lookup_address,
    input  logic [1:0]            lookup_size,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data,
    output logic                  lookup_stall,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);

    // The entry type is fixed by the package; reject mismatching overrides.
    if (ADDR_BITS != SDB_ADDR_BITS || DATA_WIDTH != SDB_DATA_WIDTH || MICROOP != SDB_MICROOP) begin : g_width_check
        $error("store_drain_buffer: widths must match store_entry_t");
    end

    store_entry_t     entries_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             push;
    logic             pop;

    assign full         = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty        = (count_reg == '0);
    assign commit_ready = ~full;
    assign wb_valid     = ~empty;
    assign push         = commit_valid && commit_ready;
    assign pop          = wb_valid && wb_ready;

    // Head entry is gated so wb_* read zero whenever nothing is presented.
    assign wb_address = wb_valid ? entries_reg[head_reg].address : '0;
    assign wb_data    = wb_valid ? entries_reg[head_reg].data    : '0;
    assign wb_microop = wb_valid ? entries_reg[head_reg].microop : '0;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            // push and pop never address the same slot: that needs head==tail,
            // which means empty (no pop) or full (no push).
            if (pop) begin
                head_reg            <= head_reg + 1'b1;
                valid_reg[head_reg] <= 1'b0;
            end
            if (push) begin
                tail_reg            <= tail_reg + 1'b1;
                valid_reg[tail_reg] <= 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Payload storage carries no reset; valid bits and gating cover it.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_reg[tail_reg] <= '{address: commit_address,
                                       data:    commit_data,
                                       microop: commit_microop};
        end
    end

    store_drain_buffer_fwd_search #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_search (
        .entries        (entries_reg),
        .valid          (valid_reg),
        .head           (head_reg),
        .tail           (tail_reg),
        .lookup_address (lookup_address),
        .lookup_size    (lookup_size),
        .hit            (lookup_hit),
        .stall          (lookup_stall),
        .data           (lookup_data)
    );

    // Protocol checks (simulation only). A push while full is dropped by
    // design, so it is reported as a warning; a misaligned SH is a real bug.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(commit_valid && full))
                else $warning("store_drain_buffer: commit while full, store dropped");
            assert (!(push && commit_microop == MO_SH && commit_address[0]))
                else $error("store_drain_buffer: misaligned SH committed");
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
module tb_store_drain_buffer;
    import store_drain_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_address = '0;
    logic [31:0] commit_data = '0;
    logic [4:0]  commit_microop = '0;
    logic        commit_ready;
    logic        wb_valid;
    logic [31:0] wb_address;
    logic [31:0] wb_data;
    logic [4:0]  wb_microop;
    logic        wb_ready = 1'b0;
    logic [31:0] lookup_address = '0;
    logic [1:0]  lookup_size = '0;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        lookup_stall;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_drain_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_address (commit_address),
        .commit_data    (commit_data),
        .commit_microop (commit_microop),
        .commit_ready   (commit_ready),
        .wb_valid       (wb_valid),
        .wb_address     (wb_address),
        .wb_data        (wb_data),
        .wb_microop     (wb_microop),
        .wb_ready       (wb_ready),
        .lookup_address (lookup_address),
        .lookup_size    (lookup_size),
        .lookup_hit     (lookup_hit),
        .lookup_data    (lookup_data),
        .lookup_stall   (lookup_stall),
        .empty          (empty),
        .full           (full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        commit_valid = 1'b0;
        wb_ready     = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [4:0] mo);
        commit_valid   = 1'b1;
        commit_address = a;
        commit_data    = d;
        commit_microop = mo;
        tick();
        commit_valid = 1'b0;
        $display("push addr=%h data=%h microop=%b", a, d, mo);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_commit_ready got=%b exp=1", commit_ready); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++; if (lookup_hit !== 1'b0 || lookup_stall !== 1'b0) begin n_fail++; $display("FAIL reset_lookup got hit=%b stall=%b exp 0/0", lookup_hit, lookup_stall); end
        n_checks++; if (wb_address !== 32'h0 || wb_data !== 32'h0 || lookup_data !== 32'h0) begin n_fail++; $display("FAIL reset_zero_data got addr=%h data=%h ldata=%h exp 0", wb_address, wb_data, lookup_data); end
    endtask

    task automatic test_fill_drain();
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_store(32'h100 + 32'(4 * k), 32'hA0 + 32'(k), MO_SW);
        n_checks++; if (full !== 1'b1 || commit_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%b ready=%b exp 1/0", full, commit_ready); end
        n_checks++; if (wb_address !== 32'h100) begin n_fail++; $display("FAIL fill_head_addr got=%h exp=00000100", wb_address); end
        tick();
        n_checks++; if (wb_address !== 32'h100 || wb_data !== 32'hA0) begin n_fail++; $display("FAIL hold_stable got addr=%h data=%h exp 100/a0", wb_address, wb_data); end
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL drain_%0d got valid=%b data=%h exp 1/%h", k, wb_valid, wb_data, 32'hA0 + 32'(k)); end
            $display("drain data=%h addr=%h", wb_data, wb_address);
            tick();
        end
        wb_ready = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got empty=%b valid=%b exp 1/0", empty, wb_valid); end
    endtask

    task automatic test_back_to_back();
        wb_ready     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            commit_valid   = 1'b1;
            commit_address = 32'h500 + 32'(4 * k);
            commit_data    = 32'hC0 + 32'(k);
            commit_microop = MO_SW;
            #1;
            if (k == 0) begin
                n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_bypass got valid=%b exp 0", wb_valid); end
            end else begin
                n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hC0 + 32'(k - 1) || full !== 1'b0) begin
                    n_fail++; $display("FAIL stream_%0d got valid=%b data=%h full=%b exp 1/%h/0", k, wb_valid, wb_data, full, 32'hC0 + 32'(k - 1));
                end
                $display("stream drain data=%h", wb_data);
            end
            tick();
        end
        commit_valid = 1'b0;
        #1;
        n_checks++; if (wb_data !== 32'hC9) begin n_fail++; $display("FAIL stream_last got=%h exp=c9", wb_data); end
        tick();
        wb_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got=%b exp 1", empty); end
    endtask

    task automatic test_lookup_hit();
        do_reset();
        push_store(32'h200, 32'h11, MO_SW);
        push_store(32'h200, 32'h22, MO_SW);
        lookup_address = 32'h200;
        lookup_size    = 2'd2;
        #1;
        n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h22 || lookup_stall !== 1'b0) begin
            n_fail++; $display("FAIL hit_young got hit=%b data=%h stall=%b exp 1/22/0", lookup_hit, lookup_data, lookup_stall);
        end
        // Drain, then pass one filler through so head=tail=3.
        wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_ready = 1'b0;
        push_store(32'h900, 32'h99, MO_SW);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        push_store(32'h200, 32'h11, MO_SW);
        push_store(32'h200, 32'h22, MO_SW);
        #1;
        n_checks++; if (wb_data !== 32'h11) begin n_fail++; $display("FAIL wrap_head got=%h exp=11", wb_data); end
        n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h22 || lookup_stall !== 1'b0) begin
            n_fail++; $display("FAIL hit_wrap got hit=%b data=%h stall=%b exp 1/22/0", lookup_hit, lookup_data, lookup_stall);
        end
    endtask

    task automatic test_lookup_stall();
        do_reset();
        push_store(32'h301, 32'h55, MO_SB);
        lookup_address = 32'h300;
        lookup_size    = 2'd2;
        #1;
        n_checks++; if (lookup_stall !== 1'b1 || lookup_hit !== 1'b0) begin n_fail++; $display("FAIL stall_word got stall=%b hit=%b exp 1/0", lookup_stall, lookup_hit); end
        lookup_address = 32'h302;
        lookup_size    = 2'd0;
        #1;
        n_checks++; if (lookup_stall !== 1'b0 || lookup_hit !== 1'b0) begin n_fail++; $display("FAIL no_overlap got stall=%b hit=%b exp 0/0", lookup_stall, lookup_hit); end
        lookup_address = 32'h301;
        #1;
        n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h55 || lookup_stall !== 1'b0) begin
            n_fail++; $display("FAIL byte_hit got hit=%b data=%h stall=%b exp 1/55/0", lookup_hit, lookup_data, lookup_stall);
        end
        lookup_address = 32'h0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int k = 0; k < 3; k++) push_store(32'h600 + 32'(4 * k), 32'hE0 + 32'(k), MO_SW);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (wb_valid !== 1'b0 || empty !== 1'b1 || commit_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset got valid=%b empty=%b ready=%b exp 0/1/1", wb_valid, empty, commit_ready);
        end
        tick();
        rst      = 1'b0;
        wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_write_%0d got valid=%b data=%h exp 0", k, wb_valid, wb_data); end
            tick();
        end
        wb_ready = 1'b0;
    endtask

    task automatic test_push_while_full();
        do_reset();
        for (int k = 0; k < 4; k++) push_store(32'h400 + 32'(4 * k), 32'hB0 + 32'(k), MO_SW);
        commit_valid   = 1'b1;
        commit_address = 32'h4F0;
        commit_data    = 32'hDEAD;
        commit_microop = MO_SW;
        wb_ready       = 1'b1;
        #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp 0", commit_ready); end
        tick();
        commit_valid = 1'b0;
        wb_ready     = 1'b0;
        #1;
        n_checks++; if (full !== 1'b0 || empty !== 1'b0 || wb_data !== 32'hB1) begin
            n_fail++; $display("FAIL full_pop got full=%b empty=%b data=%h exp 0/0/b1", full, empty, wb_data);
        end
        wb_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hB0 + 32'(k)) begin n_fail++; $display("FAIL full_drain_%0d got valid=%b data=%h exp 1/%h", k, wb_valid, wb_data, 32'hB0 + 32'(k)); end
            $display("drain data=%h", wb_data);
            tick();
        end
        wb_ready = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL dropped_absent got empty=%b valid=%b data=%h exp 1/0", empty, wb_valid, wb_data); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_lookup_hit();
        test_lookup_stall();
        test_reset_mid_drain();
        test_push_while_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- FIFO of committed stores, written by ROB retirement, drained in order to the data cache write port.
- Sits directly downstream of the load/store unit's store path: stores leave the LSU to the ROB, retire here, then go to the cache.
- Drives the LSU port-hazard signal (cache_writeback_valid).
- Provides a youngest-first forwarding lookup so loads cannot bypass buffered committed stores.

Parameters:
- DEPTH, 4, number of store entries (power of two, >=2)
- ADDR_BITS, 32, address width
- DATA_WIDTH, 32, store data width
- MICROOP, 5, microoperation width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- commit_valid  in  1  ROB retires a store this cycle
- commit_address  in  ADDR_BITS  store address
- commit_data  in  DATA_WIDTH  store data (register format, low bytes significant)
- commit_microop  in  MICROOP  store microop (SB=00110, SH=00111, SW=01000)
- commit_ready  out  1  buffer can accept a store
- wb_valid  out  1  head entry presented to cache; also routed to LSU cache_writeback_valid
- wb_address  out  ADDR_BITS  head address
- wb_data  out  DATA_WIDTH  head data
- wb_microop  out  MICROOP  head microop
- wb_ready  in  1  cache accepts head this cycle
- lookup_address  in  ADDR_BITS  load address to check
- lookup_size  in  2  load size: 0 byte, 1 half, 2 word
- lookup_hit  out  1  forwardable match
- lookup_data  out  DATA_WIDTH  forwarded store data
- lookup_stall  out  1  overlapping but non-forwardable store present
- empty  out  1  no entries
- full  out  1  DEPTH entries held

Behaviour:
- Storage: circular array with head pointer, tail pointer and count. Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset (async, rst=1): head=tail=count=0. All valid bits cleared. Resulting outputs: commit_ready=1, wb_valid=0, empty=1, full=0, lookup_hit=0, lookup_stall=0. wb_* and lookup_data read 0. Reset asserted mid-drain discards every entry with no further cache write.
- Push: when commit_valid && commit_ready, write at tail and tail++.
  - commit_ready = ~full. It is registered-state only, with no combinational path from wb_ready.
  - commit_valid while full is a protocol error. The push is dropped and a simulation assertion fires.
- Pop: when wb_valid && wb_ready, head++.
  - wb_valid = ~empty.
  - wb_* present the head entry combinationally from storage.
- Simultaneous push and pop: count unchanged. Both pointers advance.
- Latency: a store pushed at cycle N appears on wb_valid / lookup at N+1 at the earliest. There is no bypass from commit_* to wb_* or to lookup.
- Drain order: strictly FIFO. wb_* must hold stable while wb_valid && !wb_ready.
- Byte masks, computed for each entry and for the lookup (a = address[1:0]):
  - Store masks: SB → 1<<a; SH → 3<<a; SW → 4'hF.
  - Lookup masks use the same rule with size 0/1/2.
  - An entry overlaps the lookup when address[ADDR_BITS-1:2] is equal and mask AND is nonzero.
- Lookup, purely combinational over valid entries:
  - Select the youngest overlapping entry, searching from tail-1 back to head.
  - If its address equals lookup_address exactly and its size equals lookup_size: lookup_hit=1, lookup_data=entry data, lookup_stall=0.
  - Else if any entry overlaps: lookup_stall=1, lookup_hit=0.
  - Else: both 0.
  - lookup_hit and lookup_stall are never both 1.
  - Age order must be correct across pointer wrap-around.
- Misaligned SH (a[0]=1) is never pushed; a simulation assertion checks this.

Decomposition:
- Shared package holds:
  - store_entry_t typedef {address, data, microop}
  - constants for the SB/SH/SW microop codes
  - function byte_mask(size, a[1:0])
  - function store_size(microop)
- Sub-module fwd_search: the combinational youngest-first overlap/priority search, taking the entry array, valid vector and head/tail, and producing hit/stall/data. The FIFO control stays in the top level.

Test Plan:
- Reset then 4 pushes (SW @0x100..0x10C, data 0xA0..0xA3) with wb_ready=0 → full=1, commit_ready=0, wb_address=0x100 held stable. Then wb_ready=1 drains 0xA0..0xA3 in order over 4 cycles, and empty=1 afterwards.
- Continuous push+pop with wb_ready=1, 10 stores → count stays 1 and pointers wrap twice. All 10 stores reach the cache in order with 1-cycle latency.
- Lookup hit: buffer holds SW @0x200 data 0x11 then SW @0x200 data 0x22; lookup 0x200 size 2 → lookup_hit=1, lookup_data=0x22. Repeat after wrap (head=3, tail=1) → still 0x22.
- Lookup stall: buffer holds SB @0x301; lookup 0x300 size 2 → lookup_stall=1. Lookup 0x302 size 0 → hit=0 and stall=0.
- Assert rst for 1 cycle with 3 entries pending and wb_ready=0 → immediately wb_valid=0, empty=1, commit_ready=1. No cache write occurs after release.
- Push and pop in the same cycle while full (wb_ready=1, commit_valid=1) → push dropped and assertion fires. Count goes 4→3 and the dropped data never appears on wb_*.
